rv32_dec_exec_mem: RTL and testbench

- Combinational RV32I decode, ALU and data-memory datapath slice of the single-cycle core.
- Takes the fetched instruction, PC and register-file read data.
- Produces register addresses, write enable, immediate, ALU result and load data. Writeback muxing, PC update and load sign/zero extension stay in the core top.
- Contains a word-organised data RAM with byte-lane write masks.

---
 rtl/rv32_dec_exec_mem_pkg.sv | 36 +++
 rtl/rv32_alu_core.sv | 32 +++
 rtl/rv32_dmem_core.sv | 60 ++++++
 rtl/rv32_idu_core.sv | 101 ++++++++++
 rtl/rv32_dec_exec_mem.sv | 86 ++++++++
 tb/tb_rv32_dec_exec_mem.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/rv32_dec_exec_mem_pkg.sv
// Shared encodings for the RV32I decode / ALU / data-memory slice:
// opcodes, ALU op codes, operand-mux selects and instruction formats.
package rv32_dec_exec_mem_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    EU_ADD, EU_SUB, EU_AND, EU_OR, EU_XOR, EU_SLL, EU_SRL, EU_SRA
  } func_eu_e;

  typedef enum logic [1:0] {AM1_SRC1, AM1_PC, AM1_ZERO} amux1_e;
  typedef enum logic       {AM2_SRC2, AM2_IMM}          amux2_e;

  typedef enum logic [2:0] {T_NULL, T_R, T_I, T_S, T_B, T_U, T_J} inst_type_e;

  // inst[30] only means SUB on register-register ops; ADDI ignores it.
  function automatic func_eu_e alu_sel(logic [2:0] f3, logic alt, logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? EU_SUB : EU_ADD;
      3'b111:  return EU_AND;
      3'b110:  return EU_OR;
      3'b100:  return EU_XOR;
      3'b001:  return EU_SLL;
      3'b101:  return alt ? EU_SRA : EU_SRL;
      default: return EU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_core.sv
// RV32I integer ALU: add/sub, bitwise logic and shifts; arithmetic wraps mod 2^32.
module rv32_alu_core
  import rv32_dec_exec_mem_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  func_eu_e    op,
  output logic [31:0] y
);

  logic signed [31:0] a_s;
  logic        [4:0]  shamt;

  assign a_s   = a;
  assign shamt = b[4:0];

  always_comb begin
    y = a + b;
    case (op)
      EU_ADD:  y = a + b;
      EU_SUB:  y = a - b;
      EU_AND:  y = a & b;
      EU_OR:   y = a | b;
      EU_XOR:  y = a ^ b;
      EU_SLL:  y = a << shamt;
      EU_SRL:  y = a >> shamt;
      EU_SRA:  y = a_s >>> shamt;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/rv32_dmem_core.sv
// Word-organised data RAM with byte-lane store masks and right-aligned,
// asynchronous load data. Out-of-range accesses read 0 and drop writes.
module rv32_dmem_core #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        ld,
  input  logic        st,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      off;
  logic             in_rng;
  logic [IDX_W-1:0] idx;
  logic [4:0]       sh;
  logic [3:0]       base_mask;
  logic [3:0]       mask;
  logic [31:0]      wdata_sh;
  logic [31:0]      rword;

  // Addresses below BASE wrap to a huge offset and fail the range test.
  assign off    = addr - BASE;
  assign in_rng = off < SPAN;
  assign idx    = off[IDX_W+1:2];
  assign sh     = {addr[1:0], 3'b000};

  always_comb begin
    base_mask = 4'b0000;
    case (size)
      3'b000:  base_mask = 4'b0001;
      3'b001:  base_mask = 4'b0011;
      3'b010:  base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  end

  assign mask     = base_mask << addr[1:0];
  assign wdata_sh = wdata << sh;

  always_ff @(posedge clk) begin
    if (!rst && st && in_rng) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign rword = mem_q[idx];
  assign rdata = (ld && in_rng) ? (rword >> sh) : '0;

endmodule

// File: rtl/rv32_idu_core.sv
// RV32I instruction decoder: register fields, immediate, write enable,
// operand selects, ALU op and load/store strobes.
module rv32_idu_core
  import rv32_dec_exec_mem_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        wen,
  output logic [31:0] imm,
  output logic [2:0]  func3,
  output logic [6:0]  opcode,
  output logic        illegal,
  output logic        ebreak,
  output logic        is_load,
  output logic        is_store,
  output amux1_e      amux1,
  output amux2_e      amux2,
  output func_eu_e    func_eu
);

  inst_type_e itype;

  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];
  assign func3  = inst[14:12];
  assign opcode = inst[6:0];
  assign ebreak = (inst & 32'hfff0707f) == 32'h00100073;

  // Unknown opcodes fall through with A = 0 and B = imm = 0, so aluout is 0.
  always_comb begin
    itype    = T_NULL;
    amux1    = AM1_ZERO;
    amux2    = AM2_IMM;
    func_eu  = EU_ADD;
    wen      = 1'b0;
    illegal  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OPC_LUI: begin
        itype = T_U;
        wen   = 1'b1;
      end
      OPC_AUIPC: begin
        itype = T_U;
        amux1 = AM1_PC;
        wen   = 1'b1;
      end
      OPC_JAL: begin
        itype = T_J;
        amux1 = AM1_PC;
        wen   = 1'b1;
      end
      OPC_JALR: begin
        itype = T_I;
        amux1 = AM1_SRC1;
        wen   = 1'b1;
      end
      OPC_OPIMM: begin
        itype   = T_I;
        amux1   = AM1_SRC1;
        func_eu = alu_sel(func3, inst[30], 1'b0);
        wen     = 1'b1;
      end
      OPC_OP: begin
        itype   = T_R;
        amux1   = AM1_SRC1;
        amux2   = AM2_SRC2;
        func_eu = alu_sel(func3, inst[30], 1'b1);
        wen     = 1'b1;
      end
      OPC_LOAD: begin
        itype   = T_I;
        amux1   = AM1_SRC1;
        wen     = 1'b1;
        is_load = 1'b1;
      end
      OPC_STORE: begin
        itype    = T_S;
        amux1    = AM1_SRC1;
        is_store = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (itype)
      T_I:     imm = {{20{inst[31]}}, inst[31:20]};
      T_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      T_U:     imm = {inst[31:12], 12'b0};
      T_J:     imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_dec_exec_mem.sv
// Combinational decode / ALU / data-memory slice of the single-cycle RV32I core.
// Writeback muxing, PC update and load extension live in the core top.
module rv32_dec_exec_mem
  import rv32_dec_exec_mem_pkg::*;
#(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        wen,
  output logic [31:0] imm,
  output logic [2:0]  func3,
  output logic [6:0]  opcode,
  output logic [31:0] aluout,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic        ebreak
);

  amux1_e      amux1;
  amux2_e      amux2;
  func_eu_e    func_eu;
  logic        is_load;
  logic        is_store;
  logic [31:0] op_a;
  logic [31:0] op_b;

  rv32_idu_core u_idu (
    .inst     (inst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .wen      (wen),
    .imm      (imm),
    .func3    (func3),
    .opcode   (opcode),
    .illegal  (illegal),
    .ebreak   (ebreak),
    .is_load  (is_load),
    .is_store (is_store),
    .amux1    (amux1),
    .amux2    (amux2),
    .func_eu  (func_eu)
  );

  always_comb begin
    op_a = '0;
    case (amux1)
      AM1_SRC1: op_a = src1;
      AM1_PC:   op_a = pc;
      default:  op_a = '0;
    endcase
  end

  assign op_b = (amux2 == AM2_IMM) ? imm : src2;

  rv32_alu_core u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (func_eu),
    .y  (aluout)
  );

  rv32_dmem_core #(
    .DEPTH (DEPTH),
    .BASE  (BASE)
  ) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .addr  (aluout),
    .ld    (is_load),
    .st    (is_store),
    .size  (func3),
    .wdata (src2),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_rv32_dec_exec_mem.sv
// Randomised bench for rv32_dec_exec_mem against a byte-addressed behavioural model.
module tb_rv32_dec_exec_mem;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          MB   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0, pc = '0, src1 = '0, src2 = '0;
  logic [4:0]  rs1, rs2, rd;
  logic        wen, illegal, ebreak;
  logic [31:0] imm, aluout, rdata;
  logic [2:0]  func3;
  logic [6:0]  opcode;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mb [MB];

  rv32_dec_exec_mem #(.DEPTH(1024), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .src1(src1), .src2(src2),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wen(wen), .imm(imm), .func3(func3),
    .opcode(opcode), .aluout(aluout), .rdata(rdata), .illegal(illegal), .ebreak(ebreak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] d, logic [2:0] f3,
                                        logic [4:0] r1, logic [11:0] im);
    return {im, r1, f3, d, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] r1, logic [4:0] r2,
                                        logic [11:0] im);
    return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                        logic [2:0] f3, logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] d, logic [19:0] im);
    return {im, d, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] d, logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_imm(logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17:        return {i[31:12], 12'b0};
      7'h6f:               return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      7'h67, 7'h03, 7'h13: return {{20{i[31]}}, i[31:20]};
      7'h23:               return {{20{i[31]}}, i[31:25], i[11:7]};
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(logic [31:0] i, logic [31:0] p,
                                        logic [31:0] s1, logic [31:0] s2);
    logic [31:0] im, b;
    int sh;
    im = m_imm(i);
    case (i[6:0])
      7'h37:               return im;
      7'h17, 7'h6f:        return p + im;
      7'h67, 7'h03, 7'h23: return s1 + im;
      7'h13, 7'h33: begin
        b  = (i[6:0] == 7'h33) ? s2 : im;
        sh = int'(b[4:0]);
        case (i[14:12])
          3'd0:    return (i[6:0] == 7'h33 && i[30]) ? s1 - b : s1 + b;
          3'd7:    return s1 & b;
          3'd6:    return s1 | b;
          3'd4:    return s1 ^ b;
          3'd1:    return s1 << sh;
          3'd5:    return i[30] ? 32'($signed(s1) >>> sh) : s1 >> sh;
          default: return s1 + b;
        endcase
      end
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [27:0] m_ctl(logic [31:0] i);
    logic legal, we, eb;
    legal = i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h03, 7'h23};
    we    = legal && (i[6:0] != 7'h23);
    eb    = (i & 32'hfff0707f) == 32'h00100073;
    return {we, !legal, eb, i[11:7], i[19:15], i[24:20], i[14:12], i[6:0]};
  endfunction

  function automatic logic [31:0] m_rdata(logic [31:0] i, logic [31:0] s1);
    logic [31:0] a, off, r;
    if (i[6:0] != 7'h03) return 32'h0;
    a   = s1 + m_imm(i);
    off = a - BASE;
    if (off >= 32'd4096) return 32'h0;
    r = 32'h0;
    for (int j = 0; j < 4; j++)
      if (int'(a[1:0]) + j < 4) r[8*j +: 8] = mb[int'(off) + j];
    return r;
  endfunction

  task automatic m_store(input logic [31:0] i, input logic [31:0] s1, input logic [31:0] s2);
    logic [31:0] a, off;
    int n;
    if (i[6:0] != 7'h23) return;
    a   = s1 + m_imm(i);
    off = a - BASE;
    if (off >= 32'd4096) return;
    n = (i[14:12] == 3'd0) ? 1 : (i[14:12] == 3'd1) ? 2 : (i[14:12] == 3'd2) ? 4 : 0;
    for (int k = 0; k < n; k++)
      if (int'(a[1:0]) + k < 4) mb[int'(off) + k] = s2[8*k +: 8];
  endtask

  // Apply one instruction mid-cycle, check every output, then let the edge commit.
  task automatic run(input string tag, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    inst = i; pc = p; src1 = a; src2 = b; rst = r;
    #1;
    chk({tag, ".ctl"}, {4'b0, wen, illegal, ebreak, rd, rs1, rs2, func3, opcode},
        {4'b0, m_ctl(i)});
    chk({tag, ".imm"}, imm, m_imm(i));
    chk({tag, ".alu"}, aluout, m_alu(i, p, a, b));
    chk({tag, ".rdata"}, rdata, m_rdata(i, a));
    if (!r) m_store(i, a, b);
  endtask

  logic [2:0] f3_alu [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] f3_ld  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0] op_bad [5] = '{7'h63, 7'h73, 7'h0f, 7'h7f, 7'h00};

  initial begin
    logic [31:0] r0, r1v, r2v, addr_b, i;
    logic [11:0] im12;
    for (int k = 0; k < MB; k++) mb[k] = 8'h00;

    for (int k = 0; k < 3; k++) run("rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("rst.illegal", {31'b0, illegal}, 32'd1);

    for (int w = 0; w < MB / 4; w++)
      run("init", enc_s(3'd2, 5'd1, 5'd2, 12'h0), 32'h0, BASE + 32'(4 * w), 32'h0, 1'b0);

    run("addi", 32'hfff00293, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("addi.imm_k", imm, 32'hffffffff);
    chk("addi.alu_k", aluout, 32'hffffffff);
    chk("addi.wen_k", {31'b0, wen}, 32'd1);
    chk("addi.rd_k", {27'b0, rd}, 32'd5);
    run("lui", 32'h123452b7, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("lui.alu_k", aluout, 32'h12345000);
    run("auipc", enc_u(7'h17, 5'd5, 20'h1), 32'h80000000, 32'h0, 32'h0, 1'b0);
    chk("auipc.alu_k", aluout, 32'h80001000);
    run("jal", enc_j(5'd1, 21'd8), 32'h80000010, 32'h0, 32'h0, 1'b0);
    chk("jal.alu_k", aluout, 32'h80000018);
    chk("jal.wen_k", {31'b0, wen}, 32'd1);
    run("jalr", enc_i(7'h67, 5'd1, 3'd0, 5'd2, 12'hffc), 32'h0, 32'h80000100, 32'h0, 1'b0);
    chk("jalr.alu_k", aluout, 32'h800000fc);
    run("sub", enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7, 1'b0);
    chk("sub.alu_k", aluout, 32'hfffffffe);
    run("sra", enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'h0, 32'h80000000, 32'd4, 1'b0);
    chk("sra.alu_k", aluout, 32'hf8000000);

    run("sw", enc_s(3'd2, 5'd1, 5'd2, 12'h0), 32'h0, 32'h80000004, 32'hdeadbeef, 1'b0);
    run("sb", enc_s(3'd0, 5'd1, 5'd2, 12'h0), 32'h0, 32'h80000005, 32'hffffff11, 1'b0);
    run("lw", enc_i(7'h03, 5'd3, 3'd2, 5'd1, 12'h0), 32'h0, 32'h80000004, 32'h0, 1'b0);
    chk("lw.rdata_k", rdata, 32'hdead11ef);
    run("lbu", enc_i(7'h03, 5'd3, 3'd4, 5'd1, 12'h0), 32'h0, 32'h80000006, 32'h0, 1'b0);
    chk("lbu.rdata_k", {24'b0, rdata[7:0]}, 32'h000000ad);
    run("sw_rst", enc_s(3'd2, 5'd1, 5'd2, 12'h0), 32'h0, 32'h80000004, 32'h12345678, 1'b1);
    run("lw_rst", enc_i(7'h03, 5'd3, 3'd2, 5'd1, 12'h0), 32'h0, 32'h80000004, 32'h0, 1'b0);
    chk("lw_rst.rdata_k", rdata, 32'hdead11ef);
    run("sw_oor", enc_s(3'd2, 5'd1, 5'd2, 12'h0), 32'h0, BASE + 32'h1000, 32'h55aa55aa, 1'b0);
    run("lw_w0", enc_i(7'h03, 5'd3, 3'd2, 5'd1, 12'h0), 32'h0, BASE, 32'h0, 1'b0);
    run("lw_low", enc_i(7'h03, 5'd3, 3'd2, 5'd1, 12'hffc), 32'h0, BASE, 32'h0, 1'b0);
    chk("lw_low.rdata_k", rdata, 32'h0);
    run("ill", 32'h0000007f, 32'h0, 32'h1234, 32'h5678, 1'b0);
    chk("ill.illegal_k", {31'b0, illegal}, 32'd1);
    chk("ill.wen_k", {31'b0, wen}, 32'd0);
    run("ebreak", 32'h00100073, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("ebreak.k", {31'b0, ebreak}, 32'd1);

    for (int n = 0; n < 500; n++) begin
      r0  = $urandom;
      r1v = $urandom;
      r2v = $urandom;
      im12 = 12'($urandom_range(0, 31)) - 12'd16;
      addr_b = ($urandom_range(0, 7) == 0) ? BASE + 32'h1010 + 32'($urandom_range(0, 15))
                                           : BASE + 32'($urandom_range(0, 47));
      case ($urandom_range(0, 8))
        0: i = enc_u(7'h37, r0[4:0], r0[31:12]);
        1: i = enc_u(7'h17, r0[4:0], r0[31:12]);
        2: i = enc_j(r0[4:0], {r0[31:12], 1'b0});
        3: i = enc_i(7'h67, r0[4:0], 3'd0, r0[9:5], r0[31:20]);
        4: i = enc_i(7'h13, r0[4:0], f3_alu[$urandom_range(0, 5)], r0[9:5], r0[31:20]);
        5: i = enc_r({1'b0, r0[30], 5'b0}, r0[14:10], r0[9:5],
                     f3_alu[$urandom_range(0, 5)], r0[4:0]);
        6: begin
          i = enc_i(7'h03, r0[4:0], f3_ld[$urandom_range(0, 4)], r0[9:5], im12);
          r1v = addr_b;
        end
        7: begin
          i = enc_s(3'($urandom_range(0, 2)), r0[9:5], r0[14:10], im12);
          r1v = addr_b;
        end
        default: begin
          i = {r0[31:7], op_bad[$urandom_range(0, 4)]};
          if (r0[0]) i = 32'h00100073 | (r0 & 32'h000f8f80);
        end
      endcase
      run("rnd", i, $urandom, r1v, r2v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
